// File: rtl/counter_ctrl_pkg.sv
// ============================================================================
// Module      : pack (package)
// Description : Shared op/state encodings and width defaults for counter_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pack;

    typedef enum logic [1:0] {
        OP_LOAD    = 2'b00,
        OP_UP      = 2'b01,
        OP_DOWN    = 2'b10,
        OP_ILLEGAL = 2'b11
    } ctrl_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } ctrl_state_e;

    localparam int c_default_width      = 4;
    localparam int c_default_prescale_w = 4;

endpackage

`default_nettype wire

// File: rtl/counter_ctrl_ce_prescaler.sv
// ============================================================================
// Module      : ce_prescaler
// Description : Free-running prescale counter; tick when it reaches pscale_q.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ce_prescaler
    import pack::*;
#(
    parameter int PRESCALE_W = c_default_prescale_w
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] pscale_q,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] r_pcnt;

    assign tick = (r_pcnt == pscale_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (clr || tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + PRESCALE_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/counter_ctrl.sv
// ============================================================================
// Module      : counter_ctrl
// Description : LOAD/UP/DOWN command sequencer for an up/down counter.
//               Optional abort input enabled by COUNTER_CTRL_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_ctrl
    import pack::*;
#(
    parameter int WIDTH      = c_default_width,
    parameter int PRESCALE_W = c_default_prescale_w
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [WIDTH-1:0]      cmd_arg,
    input  logic [PRESCALE_W-1:0] prescale,
`ifdef COUNTER_CTRL_ABORT_EN
    input  logic                  abort,
`endif
    input  logic                  max_count,
    input  logic                  zero,
    output logic                  load_n,
    output logic                  ce,
    output logic                  up_down,
    output logic [WIDTH-1:0]      data_load,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    ctrl_state_e           r_state;
    ctrl_state_e           w_state_nxt;
    logic [WIDTH-1:0]      r_remaining;
    logic [PRESCALE_W-1:0] r_pscale;
    logic                  r_up_down;
    logic [WIDTH-1:0]      r_data_load;
    logic                  r_err;
    logic                  w_err_nxt;
    logic                  w_ce;
    logic                  w_load_n;
    logic                  w_tick;
    logic                  w_term;
    logic                  w_accept;
    logic                  w_abort;
    ctrl_op_e              w_op;

`ifdef COUNTER_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_op      = ctrl_op_e'(cmd_op);
    assign w_accept  = cmd_valid && (r_state == ST_IDLE);
    // Terminal flag follows the latched direction so the counter never wraps
    assign w_term    = r_up_down ? max_count : zero;

    assign cmd_ready = (r_state == ST_IDLE) && !rst;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign err       = r_err;
    assign ce        = w_ce;
    assign load_n    = w_load_n;
    assign up_down   = r_up_down;
    assign data_load = r_data_load;

    ce_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_ce_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clr      (r_state != ST_RUN),
        .pscale_q (r_pscale),
        .tick     (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ce        = 1'b0;
        w_load_n    = 1'b1;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_op)
                        OP_LOAD:         w_state_nxt = ST_LOAD;
                        OP_UP, OP_DOWN:  w_state_nxt = ST_RUN;
                        default:         w_err_nxt   = 1'b1;
                    endcase
                end
            end
            ST_LOAD: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_load_n    = 1'b0;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_RUN: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                end else if (w_tick) begin
                    if (w_term) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_ce = 1'b1;
                        if (r_remaining == WIDTH'(1)) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_pscale    <= '0;
            r_up_down   <= 1'b1;
            r_data_load <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
            if (w_accept) begin
                r_remaining <= cmd_arg;
                r_pscale    <= prescale;
                if (w_op == OP_LOAD) begin
                    r_data_load <= cmd_arg;
                end
                if (w_op == OP_UP) begin
                    r_up_down <= 1'b1;
                end else if (w_op == OP_DOWN) begin
                    r_up_down <= 1'b0;
                end
            end else if (w_ce && (r_remaining > WIDTH'(1))) begin
                // A zero count means unlimited and is never decremented
                r_remaining <= r_remaining - WIDTH'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_counter_ctrl.sv
// ============================================================================
// Module      : tb_counter_ctrl
// Description : Directed bench for counter_ctrl with an attached counter model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_ctrl;
    import pack::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_arg = 4'h0;
    logic [3:0] prescale = 4'h0;
    logic       abort = 1'b0;
    logic       max_count;
    logic       zero;
    logic       load_n;
    logic       ce;
    logic       up_down;
    logic [3:0] data_load;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n      = 0;

    int q_ce[$];
    int q_done[$];
    int q_err[$];
    int q_load_cyc[$];
    int q_load_val[$];

    counter_ctrl #(
        .WIDTH      (4),
        .PRESCALE_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .prescale  (prescale),
`ifdef COUNTER_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .max_count (max_count),
        .zero      (zero),
        .load_n    (load_n),
        .ce        (ce),
        .up_down   (up_down),
        .data_load (data_load),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream up/down counter being sequenced
    logic [3:0] cnt;
    always @(posedge clk or posedge rst) begin
        if (rst)        cnt <= 4'h0;
        else if (!load_n) cnt <= data_load;
        else if (ce)    cnt <= up_down ? cnt + 4'd1 : cnt - 4'd1;
    end
    assign max_count = (cnt == 4'hF);
    assign zero      = (cnt == 4'h0);

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every output pulse must match the head of its queue
    always @(negedge clk) begin
        if (!rst) begin
            if (ce) begin
                if (q_ce.size() == 0) check("ce_unexpected", cyc, -1);
                else                  check("ce_cycle", cyc, q_ce.pop_front());
            end
            if (done) begin
                if (q_done.size() == 0) check("done_unexpected", cyc, -1);
                else                    check("done_cycle", cyc, q_done.pop_front());
            end
            if (err) begin
                if (q_err.size() == 0) check("err_unexpected", cyc, -1);
                else                   check("err_cycle", cyc, q_err.pop_front());
            end
            if (!load_n) begin
                if (q_load_cyc.size() == 0) begin
                    check("load_unexpected", cyc, -1);
                end else begin
                    check("load_cycle", cyc, q_load_cyc.pop_front());
                    check("load_value", int'(data_load), q_load_val.pop_front());
                end
            end
        end
    end

    task automatic start(input logic [1:0] op, input logic [3:0] arg, input logic [3:0] ps);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        prescale  = ps;
        n         = cyc + 1;
    endtask

    task automatic accept();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("idle_timeout", int'(busy), 0);
        check("q_ce_empty", q_ce.size(), 0);
        check("q_done_empty", q_done.size() + q_err.size() + q_load_cyc.size(), 0);
    endtask

    task automatic do_load(input logic [3:0] v);
        start(2'b00, v, 4'h0);
        q_load_cyc.push_back(n);
        q_load_val.push_back(int'(v));
        q_done.push_back(n + 1);
        accept();
        wait_idle();
        check("load_cnt", int'(cnt), int'(v));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        check("rst_cmd_ready", int'(cmd_ready), 0);
        check("rst_load_n", int'(load_n), 1);
        check("rst_ce", int'(ce), 0);
        check("rst_up_down", int'(up_down), 1);
        check("rst_data_load", int'(data_load), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done_err", int'({done, err}), 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", int'(cmd_ready), 1);

        // LOAD 4'hA: one load cycle, done next, busy two cycles
        start(2'b00, 4'hA, 4'h0);
        q_load_cyc.push_back(n);
        q_load_val.push_back(10);
        q_done.push_back(n + 1);
        accept();
        check("load_busy_c0", int'(busy), 1);
        check("load_ready_c0", int'(cmd_ready), 0);
        @(posedge clk); #1;
        check("load_busy_c1", int'(busy), 1);
        @(posedge clk); #1;
        check("load_busy_c2", int'(busy), 0);
        check("load_ready_c2", int'(cmd_ready), 1);
        check("load_hold", int'(data_load), 10);
        wait_idle();
        check("load_a_cnt", int'(cnt), 10);

        // UP arg 3 prescale 2 from 0
        do_load(4'h0);
        start(2'b01, 4'd3, 4'd2);
        q_ce.push_back(n + 2);
        q_ce.push_back(n + 5);
        q_ce.push_back(n + 8);
        q_done.push_back(n + 9);
        accept();
        check("up_dir", int'(up_down), 1);
        wait_idle();
        check("up3_cnt", int'(cnt), 3);

        // UP unlimited prescale 0 from D: stops at F
        do_load(4'hD);
        start(2'b01, 4'd0, 4'd0);
        q_ce.push_back(n);
        q_ce.push_back(n + 1);
        q_done.push_back(n + 3);
        accept();
        wait_idle();
        check("up_sat_cnt", int'(cnt), 15);

        // DOWN arg 5 from 2: stops at zero, no wrap
        do_load(4'h2);
        start(2'b10, 4'd5, 4'd0);
        q_ce.push_back(n);
        q_ce.push_back(n + 1);
        q_done.push_back(n + 3);
        accept();
        check("down_dir", int'(up_down), 0);
        wait_idle();
        check("down_zero_cnt", int'(cnt), 0);
        check("down_dir_hold", int'(up_down), 0);

        // DOWN arg 2 prescale 1 from 5
        do_load(4'h5);
        start(2'b10, 4'd2, 4'd1);
        q_ce.push_back(n + 1);
        q_ce.push_back(n + 3);
        q_done.push_back(n + 4);
        accept();
        wait_idle();
        check("down2_cnt", int'(cnt), 3);

        // Illegal op: err next cycle, nothing else moves
        start(2'b11, 4'h7, 4'h0);
        q_err.push_back(n);
        accept();
        check("ill_busy", int'(busy), 0);
        check("ill_data_load", int'(data_load), 5);
        check("ill_up_down", int'(up_down), 0);
        @(posedge clk); #1;
        wait_idle();

        // Async reset during a ce pulse
        do_load(4'h0);
        start(2'b01, 4'd0, 4'd3);
        accept();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_ce", int'(ce), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_ce", int'(ce), 0);
        check("mid_rst_ready", int'(cmd_ready), 0);
        check("mid_rst_busy", int'(busy), 0);
        @(posedge clk); #1;
        check("mid_rst_ready2", int'(cmd_ready), 0);
        rst = 1'b0;
        #1;
        check("post_rst2_ready", int'(cmd_ready), 1);
        check("post_rst2_up_down", int'(up_down), 1);

`ifdef COUNTER_CTRL_ABORT_EN
        // Abort on a tick cycle: no ce, err pulse, no done, IDLE next
        do_load(4'h0);
        start(2'b01, 4'd0, 4'd1);
        q_ce.push_back(n + 1);
        q_err.push_back(n + 4);
        accept();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        #1;
        check("abort_ce", int'(ce), 0);
        check("abort_load_n", int'(load_n), 1);
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_idle", int'(busy), 0);
        @(posedge clk); #1;
        wait_idle();
        check("abort_cnt", int'(cnt), 1);
`endif

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
